// File: rtl/instruction_sequencer_pkg.sv
// Shared instruction format for the sequencer and the downstream decoder:
// a 9-bit word {opcode, sel_out, sel_in} addressing an 8-entry register file.
package instruction_sequencer_pkg;

  localparam int unsigned NREGS   = 8;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned SEL_W   = $clog2(NREGS);
  localparam int unsigned INSTR_W = OPC_W + 2 * SEL_W;

  typedef logic [REG_W-1:0] reg_word_t;

  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [SEL_W-1:0] sel_out;
    logic [SEL_W-1:0] sel_in;
  } instr_t;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Valid/ready link carrying one instruction from the sequencer to the decoder.
interface instruction_sequencer_if;
  import instruction_sequencer_pkg::*;

  logic [INSTR_W-1:0] instruct;
  logic               instr_valid;
  logic               instr_ready;

  modport master (output instruct, output instr_valid, input instr_ready);
  modport slave  (input instruct, input instr_valid, output instr_ready);

endinterface

// File: rtl/instruction_sequencer_prog_mem.sv
// Program store: one synchronous write port, one synchronous read port whose
// output register doubles as the instruction output register.
module instruction_sequencer_prog_mem
  import instruction_sequencer_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  instr_t        wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output instr_t        rdata_o
);

  instr_t mem_q [DEPTH];
  instr_t rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Contents survive rst; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_sequencer.sv
// Instruction sequencer: streams a loaded program to the decoder, holding each
// instruction for at least HOLD_CYCLES clocks and until the consumer accepts it.
module instruction_sequencer
  import instruction_sequencer_pkg::*;
#(
  parameter  int unsigned DEPTH       = 16,
  parameter  int unsigned HOLD_CYCLES = 4,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    prog_we,
  input  logic [AW-1:0]           prog_addr,
  input  logic [INSTR_W-1:0]      prog_data,
  input  logic [AW:0]             prog_len,
  input  logic                    start,
  input  logic                    step_mode,
  input  logic                    step,
  instruction_sequencer_if.master dec_if,
  output logic [AW-1:0]           pc,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_PAUSE,
    S_DONE
  } seq_state_t;

  localparam int unsigned   CW      = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYCLES);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

  seq_state_t    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          step_mode_q, step_mode_d;

  logic [AW:0]   len_clamped;
  logic          last_instr;
  logic          accept;
  logic          mem_we;
  logic          mem_re;
  instr_t        rd_data;

  assign len_clamped = (prog_len > DEPTH_C) ? DEPTH_C : prog_len;
  assign last_instr  = ({1'b0, pc_q} == (len_q - 1'b1));
  assign accept      = (state_q == S_ISSUE) && (cnt_q >= HOLD_C) && dec_if.instr_ready;
  assign mem_we      = prog_we && !busy_q;
  assign mem_re      = (state_q == S_FETCH);

  instruction_sequencer_prog_mem #(
    .DEPTH (DEPTH)
  ) u_prog_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (instr_t'(prog_data)),
    .re_i    (mem_re),
    .raddr_i (pc_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_mode_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      step_mode_q <= step_mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    step_mode_d = step_mode_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d       = len_clamped;
          step_mode_d = step_mode;
          if (len_clamped == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_FETCH;
            pc_d    = '0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end

      // Read issued this cycle; the store's output register becomes instruct.
      S_FETCH: begin
        state_d = S_ISSUE;
        valid_d = 1'b1;
        cnt_d   = CW'(1);
      end

      S_ISSUE: begin
        if (cnt_q < HOLD_C) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (accept) begin
          valid_d = 1'b0;
          if (last_instr) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = step_mode_q ? S_PAUSE : S_FETCH;
          end
        end
      end

      S_PAUSE: begin
        if (step) begin
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dec_if.instruct    = rd_data;
  assign dec_if.instr_valid = valid_q;
  assign pc                 = pc_q;
  assign busy               = busy_q;
  assign done               = done_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboarded bench for instruction_sequencer: directed scenarios plus
// randomized programs, lengths, step modes and consumer back-pressure.
module tb_instruction_sequencer;

  localparam int DEPTH = 16;
  localparam int HOLD  = 4;
  localparam int AW    = 4;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          prog_we   = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [8:0]    prog_data = '0;
  logic [AW:0]   prog_len  = '0;
  logic          start     = 1'b0;
  logic          step_mode = 1'b0;
  logic          step      = 1'b0;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  instruction_sequencer_if dec_if ();

  instruction_sequencer #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_len  (prog_len),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .dec_if    (dec_if),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [8:0] model_mem [DEPTH];

  typedef struct packed {
    logic [8:0]    ins;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Monitor: pops the expected instruction on every new issue and checks the
  // hold/accept rule cycle by cycle.
  initial begin : monitor
    logic       pv;
    logic       pr;
    logic [8:0] pins;
    int         vcnt;
    exp_t       e;
    pv = 1'b0; pr = 1'b0; pins = '0; vcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv   = 1'b0;
        vcnt = 0;
      end else begin
        if (pv) begin
          check("handshake", 32'(dec_if.instr_valid), 32'(!(vcnt >= HOLD && pr)));
          if (dec_if.instr_valid) check("hold_stable", 32'(dec_if.instruct), 32'(pins));
        end
        if (dec_if.instr_valid && !pv) begin
          check("issue_expected", 32'(exp_q.size() > 0), 32'(1));
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("instruct", 32'(dec_if.instruct), 32'(e.ins));
            check("issue_pc", 32'(pc), 32'(e.addr));
            $display("issue pc=%0d instruct=0x%03h expected=0x%03h", pc, dec_if.instruct, e.ins);
          end
          vcnt = 1;
        end else if (dec_if.instr_valid) begin
          vcnt++;
        end
        check("busy_done_excl", 32'(busy & done), 32'(0));
        pv   = dec_if.instr_valid;
        pr   = dec_if.instr_ready;
        pins = dec_if.instruct;
      end
    end
  end

  task automatic write_mem(input int addr, input logic [8:0] data);
    prog_we   = 1'b1;
    prog_addr = addr[AW-1:0];
    prog_data = data;
    @(posedge clk); #1;
    prog_we = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic run(input int len, input bit smode, input int ready_pct, input int stall,
                     input int step_after, input bit wr_start, input bit disturb,
                     input bit abort, output int cyc);
    int            n;
    bit            aborted;
    logic [AW-1:0] wa;
    logic [8:0]    wd;
    exp_t          e;
    n       = (len > DEPTH) ? DEPTH : len;
    aborted = 1'b0;
    if (wr_start) begin
      wa        = AW'($urandom_range(DEPTH - 1));
      wd        = 9'($urandom);
      prog_we   = 1'b1;
      prog_addr = wa;
      prog_data = wd;
      model_mem[wa] = wd;
    end
    for (int i = 0; i < n; i++) begin
      e.ins  = model_mem[i];
      e.addr = AW'(i);
      exp_q.push_back(e);
    end
    prog_len  = len[AW:0];
    step_mode = smode;
    start     = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    prog_we = 1'b0;
    cyc     = 0;
    while (!done && cyc < 3000) begin
      if (abort && dec_if.instr_valid && pc == 1) begin
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_valid", 32'(dec_if.instr_valid), 32'(0));
        check("abort_pc", 32'(pc), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_instruct", 32'(dec_if.instruct), 32'(0));
        aborted = 1'b1;
        break;
      end
      if (n > 0 && cyc == 1) begin
        check("run_busy", 32'(busy), 32'(1));
        check("run_done_cleared", 32'(done), 32'(0));
      end
      if (step_after > 0 && cyc == step_after) begin
        check("paused_valid", 32'(dec_if.instr_valid), 32'(0));
        check("paused_pc", 32'(pc), 32'(1));
        check("paused_busy", 32'(busy), 32'(1));
      end
      dec_if.instr_ready = (cyc >= stall) && ($urandom_range(99) < ready_pct);
      step = (step_after > 0) ? (cyc >= step_after) : 1'($urandom_range(1));
      prog_we = disturb && cyc == 2;
      start   = disturb && cyc == 2;
      if (disturb && cyc == 2) begin
        prog_addr = '0;
        prog_data = ~model_mem[0];
        prog_len  = 5'd1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    dec_if.instr_ready = 1'b0;
    step    = 1'b0;
    prog_we = 1'b0;
    start   = 1'b0;
    if (!aborted) begin
      check("run_finished", 32'(done), 32'(1));
      check("queue_drained", 32'(exp_q.size()), 32'(0));
      check("end_valid", 32'(dec_if.instr_valid), 32'(0));
      check("end_busy", 32'(busy), 32'(0));
      $display("run len=%0d step_mode=%0d cycles=%0d", len, smode, cyc);
      exp_q.delete();
    end
  endtask

  initial begin : stim
    int cyc;
    dec_if.instr_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_instruct", 32'(dec_if.instruct), 32'(0));
    check("rst_valid", 32'(dec_if.instr_valid), 32'(0));
    check("rst_pc", 32'(pc), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));

    for (int i = 0; i < DEPTH; i++) write_mem(i, 9'($urandom));

    run(0, 1'b0, 100, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
    check("len0_latency", 32'(cyc), 32'(0));

    write_mem(0, 9'b111_110_100);
    write_mem(1, 9'b100_110_100);
    write_mem(2, 9'b011_011_100);
    run(3, 1'b0, 100, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
    check("free_run_cycles", 32'(cyc), 32'(15));
    run(3, 1'b0, 100, 10, 0, 1'b0, 1'b0, 1'b0, cyc);
    check("stall_cycles", 32'(cyc), 32'(21));
    run(2, 1'b1, 100, 0, 12, 1'b0, 1'b0, 1'b0, cyc);
    check("step_cycles", 32'(cyc), 32'(18));
    run(20, 1'b0, 100, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
    check("clamp_cycles", 32'(cyc), 32'(80));
    run(3, 1'b0, 100, 0, 0, 1'b0, 1'b1, 1'b0, cyc);
    check("busy_ignore_cycles", 32'(cyc), 32'(15));
    run(3, 1'b0, 100, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
    run(3, 1'b0, 100, 0, 0, 1'b0, 1'b0, 1'b1, cyc);
    run(3, 1'b0, 100, 0, 0, 1'b0, 1'b0, 1'b0, cyc);
    check("replay_cycles", 32'(cyc), 32'(15));

    repeat (14) begin
      if ($urandom_range(1) == 1) write_mem(int'($urandom_range(DEPTH - 1)), 9'($urandom));
      run(int'($urandom_range(20)), 1'($urandom_range(1)), int'($urandom_range(100, 40)),
          int'($urandom_range(6)), 0, 1'($urandom_range(1)), 1'b0, 1'b0, cyc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
